// File: rtl/servant_ram_banked_if.sv
// Wishbone-style bus bundle between servant and its banked RAM.
// cyc doubles as stb; ack is a single-cycle completion pulse.
interface servant_ram_banked_if #(
    parameter int aw = 13
);
    logic [aw-1:2] adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
    logic          we;
    logic          cyc;
    logic [31:0]   rdt;
    logic          ack;

    modport master (
        output adr, dat, sel, we, cyc,
        input  rdt, ack
    );

    modport slave (
        input  adr, dat, sel, we, cyc,
        output rdt, ack
    );
endinterface

// File: rtl/servant_ram_banked.sv
// Banked servant RAM built from 1024x32 SRAM macros, with optional
// post-reset scrub and single-cycle registered ack.
module IHP_SRAM_1024x32_wrapper (
    input  logic        A_CLK,
    input  logic        A_MEN,
    input  logic        A_WEN,
    input  logic        A_REN,
    input  logic [9:0]  A_ADDR,
    input  logic [31:0] A_DIN,
    input  logic [31:0] A_BM,
    output logic [31:0] A_DOUT
);
    logic [31:0] mem [1024];

    always_ff @(posedge A_CLK) begin
        if (A_MEN && A_WEN)
            mem[A_ADDR] <= (mem[A_ADDR] & ~A_BM) | (A_DIN & A_BM);
        if (A_MEN && A_REN)
            A_DOUT <= mem[A_ADDR];
    end
endmodule

module servant_ram_banked #(
    parameter int depth          = 8192,
    parameter int aw             = $clog2(depth),
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 i_wb_clk,
    input  logic                 i_wb_rst_n,
    servant_ram_banked_if.slave  wb,
    output logic                 o_init_done
);
    localparam int NUM_BANKS = depth / 4096;
    localparam int BW        = (aw > 12) ? aw - 12 : 1;
    localparam int NB2       = 1 << BW;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_ACK
    } state_t;

    state_t       state, state_n;
    logic [9:0]   cnt, cnt_n;
    logic         init_q, init_n;
    logic         ack_q;
    logic [BW-1:0] bank, bank_q;
    logic         in_rng, in_q;
    logic         accept;

    logic         men [NB2];
    logic         wen, ren;
    logic [9:0]   addr;
    logic [31:0]  din, bm;
    logic [31:0]  dout [NB2];

    if (aw > 12) begin : g_bank_field
        assign bank = wb.adr[aw-1:12];
    end else begin : g_no_bank_field
        assign bank = '0;
    end

    assign in_rng = int'(bank) < NUM_BANKS;
    assign accept = (state == S_IDLE) && wb.cyc;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        init_n  = init_q;
        wen     = 1'b0;
        ren     = 1'b0;
        addr    = wb.adr[11:2];
        din     = wb.dat;
        bm      = {{8{wb.sel[3]}}, {8{wb.sel[2]}},
                   {8{wb.sel[1]}}, {8{wb.sel[0]}}};
        for (int b = 0; b < NB2; b++) men[b] = 1'b0;
        unique case (state)
            S_CLEAR: begin
                for (int b = 0; b < NB2; b++) men[b] = 1'b1;
                wen   = 1'b1;
                addr  = cnt;
                din   = '0;
                bm    = '1;
                cnt_n = cnt + 10'd1;
                if (cnt == 10'd1023) begin
                    state_n = S_IDLE;
                    init_n  = 1'b1;
                end
            end
            S_IDLE: begin
                if (wb.cyc) begin
                    state_n = S_ACK;
                    wen     = wb.we;
                    ren     = !wb.we;
                    for (int b = 0; b < NB2; b++)
                        men[b] = in_rng && (bank == BW'(b));
                end
            end
            S_ACK:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (!CLEAR_ON_RESET) init_n = 1'b1;
        // Macros must stay quiet while reset is held.
        for (int b = 0; b < NB2; b++) men[b] = men[b] && i_wb_rst_n;
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state  <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            cnt    <= '0;
            init_q <= 1'b0;
            ack_q  <= 1'b0;
            bank_q <= '0;
            in_q   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            init_q <= init_n;
            ack_q  <= accept;
            if (accept) begin
                bank_q <= bank;
                in_q   <= in_rng;
            end
        end
    end

    for (genvar g = 0; g < NB2; g++) begin : g_bank
        if (g < NUM_BANKS) begin : g_mac
            IHP_SRAM_1024x32_wrapper u_mac (
                .A_CLK  (i_wb_clk),
                .A_MEN  (men[g]),
                .A_WEN  (wen),
                .A_REN  (ren),
                .A_ADDR (addr),
                .A_DIN  (din),
                .A_BM   (bm),
                .A_DOUT (dout[g])
            );
        end else begin : g_absent
            assign dout[g] = '0;
        end
    end

    assign wb.ack      = ack_q;
    assign wb.rdt      = in_q ? dout[bank_q] : 32'h0;
    assign o_init_done = init_q;
endmodule

// File: tb/tb_servant_ram_banked.sv
// Bench for servant_ram_banked: behavioural memory/timing model plus
// directed vectors with hand-computed expectations.
module tb_servant_ram_banked;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_done;

    always #5 clk = ~clk;

    servant_ram_banked_if #(.aw(13)) bus ();

    servant_ram_banked #(
        .depth          (8192),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .i_wb_clk    (clk),
        .i_wb_rst_n  (rst_n),
        .wb          (bus),
        .o_init_done (init_done)
    );

    int errors = 0;
    int checks = 0;

    // Model: scrub takes 1024 cycles, then each request is acked on the
    // cycle after it is accepted and the bus is free again after the ack.
    int          m_left;
    bit          m_init, m_ack, m_rd;
    logic [31:0] m_rdt;
    logic [31:0] m_mem [2048];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 1024;
            m_init = 1'b0;
            m_ack  = 1'b0;
            m_rd   = 1'b0;
            for (int i = 0; i < 2048; i++) m_mem[i] = 32'h0;
        end else if (m_left > 0) begin
            m_left--;
            m_ack = 1'b0;
            if (m_left == 0) m_init = 1'b1;
        end else if (m_ack) begin
            m_ack = 1'b0;
        end else if (bus.cyc) begin
            m_ack = 1'b1;
            m_rd  = !bus.we;
            if (bus.we) begin
                for (int l = 0; l < 4; l++)
                    if (bus.sel[l])
                        m_mem[bus.adr][8*l +: 8] = bus.dat[8*l +: 8];
            end else begin
                m_rdt = m_mem[bus.adr];
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if (bus.ack !== m_ack || init_done !== m_init) begin
            errors++;
            $display("FAIL model_cmp t=%0t: ack=%b init=%b, expected ack=%b init=%b",
                     $time, bus.ack, init_done, m_ack, m_init);
        end
        if (m_ack && m_rd) begin
            checks++;
            if (bus.rdt !== m_rdt) begin
                errors++;
                $display("FAIL model_rdt t=%0t: got %h expected %h",
                         $time, bus.rdt, m_rdt);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic [12:2] a, input logic [31:0] d,
                        input logic [3:0] s, input logic w,
                        output logic [31:0] r, output int lat);
        bit got = 1'b0;
        bus.adr = a;
        bus.dat = d;
        bus.sel = s;
        bus.we  = w;
        bus.cyc = 1'b1;
        r   = 32'h0;
        lat = 0;
        for (int i = 1; i <= 4 && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus.ack) begin
                got = 1'b1;
                r   = bus.rdt;
                lat = i;
            end
        end
        bus.cyc = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: got no ack expected ack within 4 cycles");
        end
    endtask

    logic [31:0] rd;
    int lat, init_at, ack_at, acks, consec;
    bit prev;

    initial begin
        bus.adr = '0;
        bus.dat = '0;
        bus.sel = '0;
        bus.we  = 1'b0;
        bus.cyc = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", {31'b0, bus.ack}, 32'h0);
        check("reset_init", {31'b0, init_done}, 32'h0);

        @(posedge clk);
        #2 rst_n = 1'b1;
        init_at = 0;
        ack_at  = 0;
        for (int c = 1; c <= 1100; c++) begin
            @(posedge clk);
            #1;
            if (init_done && init_at == 0) init_at = c;
            if (bus.ack && ack_at == 0) ack_at = c;
        end
        check("scrub_cycles", init_at, 1024);
        check("first_ack_cycle", ack_at, 1025);
        bus.cyc = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        xfer(11'h7FF, 32'h0, 4'h0, 1'b0, rd, lat);
        check("read_1ffc", rd, 32'h0);
        check("ack_latency", lat, 1);

        xfer(11'h004, 32'hDEADBEEF, 4'hF, 1'b1, rd, lat);
        xfer(11'h004, 32'h0000_5500, 4'b0010, 1'b1, rd, lat);
        xfer(11'h004, 32'h0, 4'h0, 1'b0, rd, lat);
        check("byte_lane", rd, 32'hDEAD55EF);

        xfer(11'h404, 32'h12345678, 4'hF, 1'b1, rd, lat);
        xfer(11'h004, 32'h0, 4'h0, 1'b0, rd, lat);
        check("bank0_iso", rd, 32'hDEAD55EF);
        xfer(11'h404, 32'h0, 4'h0, 1'b0, rd, lat);
        check("bank1_iso", rd, 32'h12345678);

        xfer(11'h404, 32'hFFFFFFFF, 4'h0, 1'b1, rd, lat);
        xfer(11'h404, 32'h0, 4'h0, 1'b0, rd, lat);
        check("sel0_write", rd, 32'h12345678);

        repeat (2) @(posedge clk);
        #1;
        bus.adr = 11'h004;
        bus.we  = 1'b0;
        bus.cyc = 1'b1;
        acks = 0;
        consec = 0;
        prev = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.ack) acks++;
            if (bus.ack && prev) consec++;
            prev = bus.ack;
        end
        bus.cyc = 1'b0;
        check("held_cyc_acks", acks, 5);
        check("held_cyc_consec", consec, 0);

        repeat (2) @(posedge clk);
        #1;
        bus.cyc = 1'b1;
        @(posedge clk);
        #1;
        check("pre_reset_ack", {31'b0, bus.ack}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("reset_drops_ack", {31'b0, bus.ack}, 32'h0);
        check("reset_drops_init", {31'b0, init_done}, 32'h0);
        bus.cyc = 1'b0;

        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (500) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_scrub_ack", {31'b0, bus.ack}, 32'h0);
        check("mid_scrub_init", {31'b0, init_done}, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        init_at = 0;
        for (int c = 1; c <= 1100; c++) begin
            @(posedge clk);
            #1;
            if (init_done && init_at == 0) init_at = c;
        end
        check("rescrub_cycles", init_at, 1024);

        xfer(11'h004, 32'h0, 4'h0, 1'b0, rd, lat);
        check("rescrub_zero", rd, 32'h0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
